// File: rtl/fft_32p_input_framer.sv
// Ping-pong framer: streams 32 samples per frame into two banks for the FFT.
// Optional FFT_IN_BITREV_EN writes each sample to its bit-reversed slot.
module fft_32p_input_framer #(
  parameter int DATA_W = 32,
  parameter int N_PTS  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [N_PTS*DATA_W-1:0]   frame_data,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [15:0]               frame_cnt,
  output logic                      align_err
);

  localparam int IW = $clog2(N_PTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PTS - 1);

  logic [DATA_W-1:0] r_bank [2][N_PTS];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [IW-1:0]     r_wr_idx;
  logic [15:0]       r_frame_cnt;
  logic              r_align_err;

  logic              w_accept;
  logic              w_wrap;
  logic              w_consume;
  logic [IW-1:0]     w_slot;

`ifdef FFT_IN_BITREV_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] n);
    logic [IW-1:0] r;
    for (int b = 0; b < IW; b++) r[b] = n[IW-1-b];
    return r;
  endfunction
  assign w_slot = bitrev(r_wr_idx);
`else
  assign w_slot = r_wr_idx;
`endif

  assign s_ready     = !r_full[r_wr_bank];
  assign w_accept    = s_valid && s_ready;
  assign w_wrap      = (r_wr_idx == LAST_IDX);
  assign frame_valid = r_full[r_rd_bank];
  assign w_consume   = frame_valid && frame_ready;
  assign frame_cnt   = r_frame_cnt;
  assign align_err   = r_align_err;

  for (genvar k = 0; k < N_PTS; k++) begin : g_out
    assign frame_data[k*DATA_W +: DATA_W] = r_bank[r_rd_bank][k];
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_bank[r_wr_bank][w_slot] <= s_data;
  end

  // fill and consume never target the same bank in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_cnt <= 16'd0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      if (w_consume) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
        r_frame_cnt       <= r_frame_cnt + 16'd1;
      end
      if (w_accept) begin
        if (w_wrap) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_idx          <= '0;
          r_align_err       <= !s_last;
        end else if (s_last) begin
          r_wr_idx    <= '0;
          r_align_err <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_32p_input_framer.sv
// Scoreboard bench for fft_32p_input_framer: directed plus random traffic
// against a frame-level reference model.
module tb_fft_32p_input_framer;

  localparam int W = 32;
  localparam int N = 32;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [15:0]   frame_cnt;
  logic          align_err;

  fft_32p_input_framer #(.DATA_W(W), .N_PTS(N)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_cnt(frame_cnt), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FW-1:0] sb[$];
  logic [FW-1:0] part;
  int            pcnt;
  int            n_full;
  logic          exp_aerr;
  int            mcnt;

  function automatic void chk(string nm, logic [FW-1:0] got,
                              logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic int slot(int n);
`ifdef FFT_IN_BITREV_EN
    int r = 0;
    for (int b = 0; b < 5; b++) if (n[b]) r |= 1 << (4 - b);
    return r;
`else
    return n;
`endif
  endfunction

  // one clock cycle; called at posedge+1
  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic l, input logic fr, output logic acc);
    logic cons;
    s_valid = v; s_data = d; s_last = l; frame_ready = fr;
    chk("s_ready", s_ready, n_full < 2);
    chk("frame_valid", frame_valid, n_full > 0);
    chk("align_err", align_err, exp_aerr);
    acc  = v && (n_full < 2);
    cons = fr && (n_full > 0);
    @(posedge clk); #1;
    exp_aerr = 1'b0;
    if (cons) n_full--;
    if (acc) begin
      part[slot(pcnt)*W +: W] = d;
      if (pcnt == N - 1) begin
        exp_aerr = !l;
        sb.push_back(part);
        n_full++;
        pcnt = 0;
      end else if (l) begin
        exp_aerr = 1'b1;
        pcnt = 0;
      end else begin
        pcnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_full = 0; pcnt = 0; exp_aerr = 1'b0; part = '0;
    sb.delete();
  endtask

  task automatic stream(input int base, input int count, input logic fr,
                        input int maxc, output int got);
    logic acc;
    got = 0;
    for (int c = 0; c < maxc && got < count; c++) begin
      step(1'b1, W'(base + got), (got % N) == N - 1, fr, acc);
      if (acc) got++;
    end
  endtask

  task automatic idle(input int n, input logic fr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, fr, acc);
  endtask

  // monitor: pops the scoreboard on every frame handshake
  always @(negedge clk) begin
    if (rst) begin
      mcnt = 0;
    end else begin
      chk("frame_cnt", frame_cnt, mcnt);
      if (frame_valid && frame_ready) begin
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexpected got=%0h exp=none", frame_data);
        end else begin
          chk("frame_data", frame_data, sb.pop_front());
        end
        mcnt++;
      end
    end
  end

  initial begin
    int   got;
    logic acc;
    n_full = 0; pcnt = 0; exp_aerr = 1'b0; part = '0; mcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    chk("reset_ready", s_ready, 1);
    chk("reset_cnt", frame_cnt, 0);

    // natural frame
    stream(0, 32, 1'b1, 40, got);
    idle(3, 1'b1);
    chk("nat_cnt", frame_cnt, 1);

    // backpressure
    do_reset();
    stream(0, 96, 1'b0, 96, got);
    chk("bp_accepted", got, 64);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("bp_cnt", frame_cnt, 1);
    chk("bp_ready", s_ready, 1);
    stream(64, 32, 1'b1, 100, got);
    idle(4, 1'b1);
    chk("bp_cnt_end", frame_cnt, 3);

    // back-to-back
    do_reset();
    stream(0, 128, 1'b1, 128, got);
    chk("b2b_accepted", got, 128);
    idle(3, 1'b1);
    chk("b2b_cnt", frame_cnt, 4);

    // early s_last, then a good frame
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, W'(i), i == 9, 1'b1, acc);
    stream(32'hA0, 32, 1'b1, 40, got);
    idle(3, 1'b1);
    chk("early_cnt", frame_cnt, 1);

    // mid-frame reset
    do_reset();
    stream(0, 20, 1'b1, 20, got);
    do_reset();
    stream(32'h100, 32, 1'b1, 40, got);
    idle(3, 1'b1);
    chk("midrst_cnt", frame_cnt, 1);

    // random traffic with occasional framing errors
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic v, l, fr;
      v  = ($urandom % 4) != 0;
      fr = ($urandom % 3) != 0;
      l  = (pcnt == N - 1);
      if (($urandom % 60) == 0) l = !l;
      step(v, $urandom, l, fr, acc);
    end
    idle(6, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_32p_input_framer.md
Name: fft_32p_input_framer

Overview:
- Upstream neighbour of the 32-point, 32-bit combinational FFT core.
- Accepts one 32-bit real sample per cycle on a valid/ready stream and assembles 32-sample frames in a ping-pong (two-bank) buffer.
- Presents each complete frame as one parallel 32-word bus to the FFT core, under a frame_valid/frame_ready handshake.
- Lets the producer keep streaming while the previous frame is still held at the FFT inputs.

Parameters:
- DATA_W, 32, width of one sample (matches FFT din width).
- N_PTS, 32, samples per frame; fixed at 32 for this core, index width log2(N_PTS)=5.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final sample of a frame from the producer.
- s_ready  out  1  framer can accept a sample this cycle.
- frame_data  out  N_PTS*DATA_W  frame; word k at bits [k*DATA_W +: DATA_W] drives FFT din k.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  FFT side consumed the frame.
- frame_cnt  out  16  completed frames delivered, wraps.
- align_err  out  1  one-cycle pulse on an s_last framing error.

Behaviour:
- Clocking and reset: one clock domain, clk; rst is synchronous and active-high.
- Reset values: s_ready=1, frame_valid=0, frame_cnt=0, align_err=0, wr_idx=0, wr_bank=0, rd_bank=0, both bank-full flags=0. frame_data contents are don't-care after reset.
- Storage: two banks, each N_PTS x DATA_W registers, plus full[1:0], wr_bank, rd_bank and wr_idx[4:0].
- Input side:
  - s_ready = !full[wr_bank] (combinational from registers only).
  - Accept occurs when s_valid && s_ready: write bank[wr_bank][wr_idx] = s_data, then wr_idx++.
  - On accepting wr_idx==31: set full[wr_bank], toggle wr_bank, set wr_idx=0.
  - s_last on the wr_idx==31 accept is the normal case.
  - s_last accepted at wr_idx!=31 is an alignment error: pulse align_err for 1 cycle, discard the partial frame (wr_idx=0, bank not marked full, same wr_bank).
  - wr_idx==31 accepted with s_last=0 is also an alignment error: pulse align_err, but the frame is still completed and delivered (count-based framing wins).
- Output side:
  - frame_valid = full[rd_bank].
  - frame_data = bank[rd_bank], stable while frame_valid=1 and frame_ready=0.
  - On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank, frame_cnt++ (wraps 0xFFFF->0).
- Latency:
  - The 32nd sample is accepted at edge N; frame_valid=1 after edge N (visible in cycle N+1).
  - Minimum sustained throughput is 1 sample/cycle with frame_ready held high; s_ready never drops in that case.
- Full condition: both banks full -> s_ready=0; no writes occur; s_data is ignored until a frame is consumed.
- Simultaneous events:
  - Bank fill and frame consume in the same cycle are both performed, touching different flags/banks.
  - If the consumed bank equals wr_bank (both full), full[wr_bank] clears and s_ready=1 next cycle. The same-cycle write is not accepted, because s_ready was 0.
- Reset mid-frame: partial frame and any full banks are dropped, frame_cnt=0. No frame_valid in the cycle after rst deasserts.
- No arithmetic on data; samples are passed bit-exact.

Optional Feature:
- Macro: FFT_IN_BITREV_EN.
- Defined: sample with arrival index n is written to slot bitrev5(n) (e.g. n=1 -> slot 16, n=3 -> slot 24), for a decimation-in-time core expecting bit-reversed input.
- Undefined: natural order, slot = n.
- The handshake, latency and error rules are identical in both builds.

Test Plan:
- Natural frame: rst, stream 0x00000000..0x0000001F with s_last on the 32nd, frame_ready=1 -> frame_valid high 1 cycle after the last accept, word k == k, frame_cnt=1, align_err never pulses.
- Backpressure: frame_ready=0, stream 96 samples with s_valid=1 -> s_ready drops after sample 64. Then frame_ready=1 for 1 cycle -> frame_cnt=1, s_ready=1 next cycle, frame 2 words == 32..63.
- Back-to-back: 4 frames of 128 continuous samples, frame_ready=1 -> s_ready stays 1 throughout, frame_cnt=4, frame j word k == 32j+k.
- Early s_last: s_last on the 10th sample, then 32 good samples 0xA0..0xBF -> align_err pulses once, and the only delivered frame has word0=0xA0, word31=0xBF.
- Mid-frame reset: 20 samples, rst for 1 cycle, then 32 samples 0x100.. -> one frame, word0=0x100, frame_cnt=1.
- FFT_IN_BITREV_EN build: stream 0..31 -> word 16 == 1, word 24 == 3, word 31 == 31.
